// File: rtl/regulator_obrotow_pkg.sv
// Shared constants for the rpm regulator: FSM encoding, stopped marker and datapath widths.
package regulator_pkg;

    localparam logic [1:0] ST_STOP    = 2'd0;
    localparam logic [1:0] ST_ROZRUCH = 2'd1;
    localparam logic [1:0] ST_PRACA   = 2'd2;

    localparam logic [8:0] TAKTOWANIE_STOP = 9'h1FF;
    localparam int         TAKTOWANIE_MAX  = 510;

    localparam int DZIELNA_W  = 12;
    localparam int DZIELNIK_W = 7;
    localparam int ILORAZ_W   = 12;
    localparam int TIMER_W    = 16;

    // 511 is reserved for "engine stopped", so running values top out at 510.
    function automatic logic [8:0] nasycenie(input logic [ILORAZ_W-1:0] iloraz);
        if (iloraz > ILORAZ_W'(TAKTOWANIE_MAX))
            return 9'(TAKTOWANIE_MAX);
        else
            return iloraz[8:0];
    endfunction

endpackage

// File: rtl/regulator_obrotow_dzielnik.sv
// Restoring divider, one quotient bit per cycle; the first bit is resolved on the start edge
// so done is high 12 cycles after the start cycle.
module dzielnik_iteracyjny
    import regulator_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [DZIELNA_W-1:0]  i_dzielna,
    input  logic [DZIELNIK_W-1:0] i_dzielnik,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ILORAZ_W-1:0]   o_iloraz
);

    logic [DZIELNIK_W-1:0] r_rem;
    logic [DZIELNA_W-1:0]  r_q;
    logic [DZIELNIK_W-1:0] r_div;
    logic [3:0]            r_cnt;
    logic                  r_busy;
    logic                  r_done;

    logic [DZIELNIK_W-1:0] w_remIn;
    logic [DZIELNA_W-1:0]  w_qIn;
    logic [DZIELNIK_W-1:0] w_divIn;
    logic [DZIELNIK_W:0]   w_trial;
    logic                  w_ge;
    logic [DZIELNIK_W-1:0] w_remNext;
    logic [DZIELNA_W-1:0]  w_qNext;

    // r_q shifts dividend bits out at the top while quotient bits enter at the bottom.
    always_comb begin
        w_remIn   = r_busy ? r_rem : '0;
        w_qIn     = r_busy ? r_q   : i_dzielna;
        w_divIn   = r_busy ? r_div : i_dzielnik;
        w_trial   = {w_remIn, w_qIn[DZIELNA_W-1]};
        w_ge      = (w_trial >= {1'b0, w_divIn});
        w_remNext = w_ge ? DZIELNIK_W'(w_trial - {1'b0, w_divIn}) : w_trial[DZIELNIK_W-1:0];
        w_qNext   = {w_qIn[DZIELNA_W-2:0], w_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_q    <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (r_busy) begin
            r_rem  <= w_remNext;
            r_q    <= w_qNext;
            r_cnt  <= r_cnt - 4'd1;
            r_done <= (r_cnt == 4'd1);
            if (r_cnt == 4'd1)
                r_busy <= 1'b0;
        end else if (i_start) begin
            r_rem  <= w_remNext;
            r_q    <= w_qNext;
            r_div  <= i_dzielnik;
            r_cnt  <= 4'd11;
            r_busy <= 1'b1;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_iloraz = r_q;

endmodule

// File: rtl/regulator_obrotow.sv
// Engine start/stop sequencer, setpoint handling and rpm ramp with cycles-per-degree conversion.
// Optional button debouncing is enabled by defining DEBOUNCE_EN.
module regulator_obrotow
    import regulator_pkg::*;
#(
    parameter int TAKTY_STALA   = 2550,
    parameter int RPM_MIN       = 6,
    parameter int RPM_MAX       = 60,
    parameter int RPM_ROZRUCH   = 5,
    parameter int CZAS_ROZRUCHU = 20000,
    parameter int OKRES_RAMPY   = 5000,
    parameter int KROK          = 2
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_przycisk_gora,
    input  logic       i_przycisk_dol,
    input  logic       i_start_stop,
    output logic [6:0] o_rpm,
    output logic [8:0] o_taktowanie_na_stopien,
    output logic       o_sygnal_zmiany_rpm,
    output logic       o_rozruch
);

    logic [2:0] r_sync1;
    logic [2:0] r_sync2;
    logic [2:0] r_prev;
    logic [2:0] w_level;
    logic [2:0] w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= {i_start_stop, i_przycisk_dol, i_przycisk_gora};
            r_sync2 <= r_sync1;
            r_prev  <= w_level;
        end
    end

`ifdef DEBOUNCE_EN
    logic [2:0]  r_stable;
    logic [15:0] r_dbCnt [3];

    // The debounced level flips only after the synchronised input disagrees for 2^16 cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < 3; i++)
                r_dbCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_dbCnt[i] <= '0;
                end else if (r_dbCnt[i] == 16'hFFFF) begin
                    r_stable[i] <= r_sync2[i];
                    r_dbCnt[i]  <= '0;
                end else begin
                    r_dbCnt[i] <= r_dbCnt[i] + 16'd1;
                end
            end
        end
    end

    assign w_level = r_stable;
`else
    assign w_level = r_sync2;
`endif

    assign w_edge = w_level & ~r_prev;

    logic w_evGora;
    logic w_evDol;
    logic w_evSs;
    assign w_evGora = w_edge[0] & ~w_edge[1];
    assign w_evDol  = w_edge[1] & ~w_edge[0];
    assign w_evSs   = w_edge[2];

    logic [1:0]         r_stan;
    logic [6:0]         r_rpm;
    logic [8:0]         r_takt;
    logic               r_strobe;
    logic               r_rozruch;
    logic [6:0]         r_setpoint;
    logic [6:0]         r_cand;
    logic               r_divStart;
    logic [TIMER_W-1:0] r_timer;
    logic               r_crankCommitted;

    logic                w_busy;
    logic                w_done;
    logic [ILORAZ_W-1:0] w_iloraz;
    logic                w_stopEntry;
    logic                w_divIdle;
    logic [6:0]          w_spUp;
    logic [6:0]          w_spDown;

    assign w_stopEntry = w_evSs && (r_stan != ST_STOP);
    assign w_divIdle   = !w_busy && !w_done && !r_divStart;

    always_comb begin
        w_spUp   = 7'(RPM_MAX);
        w_spDown = 7'(RPM_MIN);
        if (int'(r_setpoint) + KROK <= RPM_MAX)
            w_spUp = 7'(int'(r_setpoint) + KROK);
        if (int'(r_setpoint) - KROK >= RPM_MIN)
            w_spDown = 7'(int'(r_setpoint) - KROK);
    end

    dzielnik_iteracyjny u_dzielnik (
        .clk        (clk),
        .rst        (rst),
        .i_start    (r_divStart),
        .i_abort    (w_stopEntry),
        .i_dzielna  (DZIELNA_W'(TAKTY_STALA)),
        .i_dzielnik (r_cand),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_iloraz   (w_iloraz)
    );

    // r_timer counts the cranking hold in ROZRUCH and the ramp period in PRACA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stan           <= ST_STOP;
            r_rpm            <= '0;
            r_takt           <= TAKTOWANIE_STOP;
            r_strobe         <= 1'b0;
            r_rozruch        <= 1'b0;
            r_setpoint       <= 7'(RPM_MIN);
            r_cand           <= '0;
            r_divStart       <= 1'b0;
            r_timer          <= '0;
            r_crankCommitted <= 1'b0;
        end else begin
            r_strobe   <= 1'b0;
            r_divStart <= 1'b0;
            if (w_stopEntry) begin
                r_stan           <= ST_STOP;
                r_rpm            <= '0;
                r_takt           <= TAKTOWANIE_STOP;
                r_strobe         <= 1'b1;
                r_rozruch        <= 1'b0;
                r_timer          <= '0;
                r_crankCommitted <= 1'b0;
            end else begin
                if (w_done) begin
                    r_rpm    <= r_cand;
                    r_takt   <= nasycenie(w_iloraz);
                    r_strobe <= 1'b1;
                end
                case (r_stan)
                    ST_STOP: begin
                        if (w_evSs) begin
                            r_stan           <= ST_ROZRUCH;
                            r_rozruch        <= 1'b1;
                            r_cand           <= 7'(RPM_ROZRUCH);
                            r_divStart       <= 1'b1;
                            r_timer          <= '0;
                            r_crankCommitted <= 1'b0;
                        end
                    end
                    ST_ROZRUCH: begin
                        if (w_done) begin
                            r_crankCommitted <= 1'b1;
                            r_timer          <= '0;
                        end else if (r_crankCommitted) begin
                            if (r_timer == TIMER_W'(CZAS_ROZRUCHU - 1)) begin
                                r_stan    <= ST_PRACA;
                                r_rozruch <= 1'b0;
                                r_timer   <= '0;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                    end
                    ST_PRACA: begin
                        if (w_evGora)
                            r_setpoint <= w_spUp;
                        else if (w_evDol)
                            r_setpoint <= w_spDown;
                        if (r_timer == TIMER_W'(OKRES_RAMPY - 1)) begin
                            r_timer <= '0;
                            if ((r_rpm != r_setpoint) && w_divIdle) begin
                                r_cand     <= (r_rpm < r_setpoint) ? r_rpm + 7'd1 : r_rpm - 7'd1;
                                r_divStart <= 1'b1;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    default: r_stan <= ST_STOP;
                endcase
            end
        end
    end

    assign o_rpm                   = r_rpm;
    assign o_taktowanie_na_stopien = r_takt;
    assign o_sygnal_zmiany_rpm     = r_strobe;
    assign o_rozruch               = r_rozruch;

endmodule
